// File: rtl/i2c_slave_bit_shift.sv
// I2C target byte engine: filtered SCL/SDA, START/STOP detection, address match,
// write-byte delivery (Rx_*) and read-byte fetch (Tx_*); no clock stretching.
module i2c_slave_bit_shift #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned FILT_LEN   = 3
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       i2c_sclk,
  inout  wire logic  i2c_sdat,
  output logic [7:0] Rx_DATA,
  output logic       Rx_Valid,
  input  logic [7:0] Tx_DATA,
  output logic       Tx_Req,
  output logic       Start_Det,
  output logic       Stop_Det,
  output logic       Rd_nWr,
  output logic       Busy
);

  localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_IGNORE
  } state_t;

  state_t        r_state;
  // Index 1 = SCL, index 0 = SDA
  logic [1:0]    r_meta, r_sync, r_filt, r_filt_d;
  logic [CW-1:0] r_fcnt [2];
  logic [7:0]    r_shift;
  logic [2:0]    r_bit_cnt;
  logic          r_done;
  logic          r_sda_oe;

  logic w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall, w_start, w_stop;

  assign i2c_sdat = r_sda_oe ? 1'b0 : 1'bz;

  // Idle bus is high, so the conditioning chain resets to 1 to avoid false edges
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_meta   <= '1;
      r_sync   <= '1;
      r_filt   <= '1;
      r_filt_d <= '1;
      for (int unsigned i = 0; i < 2; i++) r_fcnt[i] <= '0;
    end else begin
      r_meta   <= {i2c_sclk, i2c_sdat};
      r_sync   <= r_meta;
      r_filt_d <= r_filt;
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_sync[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == CW'(FILT_LEN - 1)) begin
          r_filt[i] <= r_sync[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_scl_rise = r_filt[1] & ~r_filt_d[1];
  assign w_scl_fall = ~r_filt[1] & r_filt_d[1];
  assign w_sda_rise = r_filt[0] & ~r_filt_d[0];
  assign w_sda_fall = ~r_filt[0] & r_filt_d[0];
  assign w_start    = w_sda_fall & r_filt[1];
  assign w_stop     = w_sda_rise & r_filt[1];

  // r_done marks that the 8th (or ACK) rise has been seen, so the following
  // fall can be told apart from the fall that ends a START.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_done    <= 1'b0;
      r_sda_oe  <= 1'b0;
      Rx_DATA   <= '0;
      Rx_Valid  <= 1'b0;
      Tx_Req    <= 1'b0;
      Start_Det <= 1'b0;
      Stop_Det  <= 1'b0;
      Rd_nWr    <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      Rx_Valid  <= 1'b0;
      Tx_Req    <= 1'b0;
      Start_Det <= 1'b0;
      Stop_Det  <= 1'b0;
      if (w_start) begin
        r_sda_oe  <= 1'b0;
        r_bit_cnt <= '0;
        r_done    <= 1'b0;
        Busy      <= 1'b0;
        Start_Det <= 1'b1;
        r_state   <= S_ADDR;
      end else if (w_stop) begin
        r_sda_oe  <= 1'b0;
        r_done    <= 1'b0;
        Busy      <= 1'b0;
        Stop_Det  <= 1'b1;
        r_state   <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE, S_IGNORE: r_sda_oe <= 1'b0;
          S_ADDR, S_WR_BYTE: begin
            if (w_scl_rise) begin
              r_shift   <= {r_shift[6:0], r_filt[0]};
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_done <= 1'b1;
                if (r_state == S_WR_BYTE) begin
                  Rx_DATA  <= {r_shift[6:0], r_filt[0]};
                  Rx_Valid <= 1'b1;
                end
              end
            end else if (w_scl_fall && r_done) begin
              r_done <= 1'b0;
              if (r_state == S_WR_BYTE) begin
                r_sda_oe <= 1'b1;
                r_state  <= S_WR_ACK;
              end else if (r_shift[7:1] == SLAVE_ADDR) begin
                Rd_nWr   <= r_shift[0];
                Busy     <= 1'b1;
                r_sda_oe <= 1'b1;
                r_state  <= S_ADDR_ACK;
              end else begin
                r_state  <= S_IGNORE;
              end
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_rise && Rd_nWr) begin
              Tx_Req <= 1'b1;
            end else if (w_scl_fall) begin
              r_bit_cnt <= '0;
              if (Rd_nWr) begin
                r_shift  <= Tx_DATA;
                r_sda_oe <= ~Tx_DATA[7];
                r_state  <= S_RD_BYTE;
              end else begin
                r_sda_oe <= 1'b0;
                r_state  <= S_WR_BYTE;
              end
            end
          end
          S_WR_ACK: begin
            if (w_scl_fall) begin
              r_sda_oe  <= 1'b0;
              r_bit_cnt <= '0;
              r_state   <= S_WR_BYTE;
            end
          end
          S_RD_BYTE: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) r_done <= 1'b1;
            end else if (w_scl_fall) begin
              if (r_done) begin
                r_done   <= 1'b0;
                r_sda_oe <= 1'b0;
                r_state  <= S_RD_ACK;
              end else begin
                r_shift  <= {r_shift[6:0], 1'b0};
                r_sda_oe <= ~r_shift[6];
              end
            end
          end
          S_RD_ACK: begin
            if (w_scl_rise) begin
              if (!r_filt[0]) begin
                Tx_Req <= 1'b1;
                r_done <= 1'b1;
              end else begin
                Busy    <= 1'b0;
                r_state <= S_IGNORE;
              end
            end else if (w_scl_fall && r_done) begin
              r_done    <= 1'b0;
              r_bit_cnt <= '0;
              r_shift   <= Tx_DATA;
              r_sda_oe  <= ~Tx_DATA[7];
              r_state   <= S_RD_BYTE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
